product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter N_TERMS, default 4, number of products summed per result, legal range 1..16.
REQ-002 SHALL have parameter ACC_W, default 12, accumulator and result width, legal range 8..16.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit, rising-edge clock for all state.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1 bit, begins a new accumulation when sampled high in IDLE.
REQ-007 SHALL have port p_valid, input, 1 bit, the 8-bit multiplier product on P is valid.
REQ-008 SHALL have port P, input, 8 bits, unsigned product from the 4x4 multiply stage.
REQ-009 SHALL have port p_ready, output, 1 bit, the block accepts P this cycle.
REQ-010 SHALL have port acc_out, output, ACC_W bits, the accumulated sum.
REQ-011 SHALL have port acc_valid, output, 1 bit, acc_out holds a completed result.
REQ-012 SHALL have port acc_ready, input, 1 bit, the downstream consumer takes the result.
REQ-013 SHALL have port overflow, output, 1 bit, sticky saturation flag for the current result.
REQ-014 SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCUM and DONE, with all state held in registers.
REQ-016 IDLE behaviour:
- p_ready=0, acc_valid=0.
- start=1 -> ACCUM next cycle; accumulator, term counter and overflow cleared to 0 on that edge.
REQ-017 ACCUM behaviour:
- p_ready=1.
- A transfer occurs on a cycle with p_valid&&p_ready.
- On each transfer, acc <= sat(acc+P) and count <= count+1.
- p_valid=0 -> hold all state; no timeout.
REQ-018 On the transfer that makes count equal N_TERMS, SHALL enter DONE on the next edge.
REQ-019 DONE behaviour:
- acc_valid=1, p_ready=0, acc_out stable.
- acc_ready=1 -> IDLE next cycle.
- acc_valid SHALL hold until acc_ready is seen.
REQ-020 Latency: acc_valid SHALL rise on the first edge after the final transfer; no combinational path from P to acc_out.
REQ-021 Arithmetic: P SHALL be zero-extended to ACC_W+1 bits and added to acc.
- Sum > 2^ACC_W-1 -> acc saturates to 2^ACC_W-1 and overflow is set.
- Once saturated, acc stays at 2^ACC_W-1 for further transfers.
REQ-022 overflow SHALL remain set until the next accepted start or reset.
REQ-023 start SHALL be ignored in ACCUM and DONE; start and acc_ready together in DONE -> IDLE only, and start must be reasserted.
REQ-024 acc_out SHALL show the live accumulator in ACCUM and the final value in DONE; its value is valid only while acc_valid=1.
REQ-025 N_TERMS=1 SHALL go ACCUM->DONE on the first transfer.
REQ-026 busy SHALL be 0 in IDLE and 1 in ACCUM and DONE.

Reset
REQ-027 reset=1 at a clock edge SHALL force the following, overriding all other inputs in any state including mid-accumulation or DONE:
- state=IDLE
- acc=0, count=0
- acc_out=0, acc_valid=0, p_ready=0, overflow=0, busy=0
REQ-028 The first start SHALL be honoured on the first edge after reset deasserts.

Structure
REQ-029 SHALL place the FSM state encoding (2-bit localparams IDLE=0, ACCUM=1, DONE=2) and the product width constant (8) in the shared package exec_unit_pkg.
REQ-030 SHALL isolate the saturating adder in one combinational sub-module, sat_add, parameterized by ACC_W, with outputs sum and sat.
REQ-031 Total RTL SHALL target 120-400 lines.

Verification
REQ-032 Dot product: start, then products 2,4,64,81 with p_valid=1 each cycle -> acc_valid rises on the cycle after 81, acc_out=151, overflow=0.
REQ-033 Backpressure and gaps:
- Products 100,100,100,100 with a p_valid=0 cycle between each, acc_ready held 0 for 3 cycles -> acc_out=400 held stable, acc_valid held until acc_ready.
REQ-034 Saturation with ACC_W=8, N_TERMS=2:
- Products 200,100 -> acc_out=255, overflow=1.
- Next start -> overflow cleared to 0.
REQ-035 Reset mid-op: reset after 2 of 4 transfers -> all outputs 0, state IDLE; a new start with 1,1,1,1 -> acc_out=4.
REQ-036 Ignored inputs:
- start pulsed in ACCUM -> count not cleared.
- p_valid=1 in IDLE -> p_ready=0 and no accumulation.
- N_TERMS=1 with product 225 -> acc_out=225 one cycle later.

Source files
------------

// File: rtl/exec_unit_pkg.sv
// Shared constants and FSM state encoding for the execution-unit accumulator slice.
package exec_unit_pkg;

  localparam int unsigned P_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_add.sv
// Saturating adder: zero-extends the product to ACC_W+1 bits, clamps to all-ones on carry-out.
module sat_add
  import exec_unit_pkg::*;
#(
  parameter int unsigned ACC_W = 12
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [P_W-1:0]   b_i,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  logic [ACC_W:0] wide;

  always_comb begin
    wide = {1'b0, a_i} + {{(ACC_W + 1 - P_W){1'b0}}, b_i};
    sat  = wide[ACC_W];
    sum  = sat ? '1 : wide[ACC_W-1:0];
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums N_TERMS unsigned 8-bit products with saturation, then holds the result until taken.
module product_accumulator
  import exec_unit_pkg::*;
#(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             p_valid,
  input  logic [P_W-1:0]   P,
  output logic             p_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(N_TERMS + 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   sum;
  logic               sat;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a_i (acc_q),
    .b_i (P),
    .sum (sum),
    .sat (sat)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    p_ready   = 1'b0;
    acc_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ACCUM: begin
        p_ready = 1'b1;
        if (p_valid) begin
          acc_d = sum;
          ovf_d = ovf_q | sat;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N_TERMS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        acc_valid = 1'b1;
        // start is deliberately ignored here even alongside acc_ready
        if (acc_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_out  = acc_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator across three parameter sets selected by sel.
module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       s_start, s_p_valid, s_acc_ready;
  logic [7:0] P;
  int         sel;

  logic [2:0]  st_v, pv_v, ar_v, pr_v, av_v, ov_v, bz_v;
  logic [11:0] acc0, acc2;
  logic [7:0]  acc1;

  logic [15:0] obs_acc;
  logic        obs_valid, obs_ready, obs_ovf, obs_busy;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      st_v[k] = s_start     && (sel == k);
      pv_v[k] = s_p_valid   && (sel == k);
      ar_v[k] = s_acc_ready && (sel == k);
    end
  end

  product_accumulator #(.N_TERMS(4), .ACC_W(12)) u_dut0 (
    .clk(clk), .reset(reset), .start(st_v[0]), .p_valid(pv_v[0]), .P(P),
    .p_ready(pr_v[0]), .acc_out(acc0), .acc_valid(av_v[0]), .acc_ready(ar_v[0]),
    .overflow(ov_v[0]), .busy(bz_v[0]));

  product_accumulator #(.N_TERMS(2), .ACC_W(8)) u_dut1 (
    .clk(clk), .reset(reset), .start(st_v[1]), .p_valid(pv_v[1]), .P(P),
    .p_ready(pr_v[1]), .acc_out(acc1), .acc_valid(av_v[1]), .acc_ready(ar_v[1]),
    .overflow(ov_v[1]), .busy(bz_v[1]));

  product_accumulator #(.N_TERMS(1), .ACC_W(12)) u_dut2 (
    .clk(clk), .reset(reset), .start(st_v[2]), .p_valid(pv_v[2]), .P(P),
    .p_ready(pr_v[2]), .acc_out(acc2), .acc_valid(av_v[2]), .acc_ready(ar_v[2]),
    .overflow(ov_v[2]), .busy(bz_v[2]));

  always_comb begin
    case (sel)
      1:       obs_acc = {8'd0, acc1};
      2:       obs_acc = {4'd0, acc2};
      default: obs_acc = {4'd0, acc0};
    endcase
    obs_valid = av_v[sel];
    obs_ready = pr_v[sel];
    obs_ovf   = ov_v[sel];
    obs_busy  = bz_v[sel];
  end

  typedef struct {
    logic [15:0] acc;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0, failures = 0;
  int   n_pushed = 0, n_popped = 0;
  int   m_acc, m_cnt;
  bit   m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int n_terms_of(input int s);
    return (s == 0) ? 4 : (s == 1) ? 2 : 1;
  endfunction

  function automatic int acc_max_of(input int s);
    return (s == 1) ? 255 : 4095;
  endfunction

  always @(negedge clk) begin
    if (obs_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_valid", 32'(obs_valid), 32'd0);
      end else begin
        check_eq("acc_out", 32'(obs_acc), 32'(sb_q[0].acc));
        check_eq("overflow_done", 32'(obs_ovf), 32'(sb_q[0].ovf));
        if (s_acc_ready) begin
          void'(sb_q.pop_front());
          n_popped++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_cnt = 0;
    check_eq("rst_acc_out",  32'(obs_acc),   32'd0);
    check_eq("rst_valid",    32'(obs_valid), 32'd0);
    check_eq("rst_p_ready",  32'(obs_ready), 32'd0);
    check_eq("rst_overflow", 32'(obs_ovf),   32'd0);
    check_eq("rst_busy",     32'(obs_busy),  32'd0);
  endtask

  task automatic start_job();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    check_eq("busy_accum",    32'(obs_busy),  32'd1);
    check_eq("p_ready_accum", 32'(obs_ready), 32'd1);
  endtask

  task automatic send(input int p);
    s_p_valid = 1'b1;
    P = 8'(p);
    tick();
    s_p_valid = 1'b0;
    m_acc += p;
    if (m_acc > acc_max_of(sel)) begin
      m_acc = acc_max_of(sel);
      m_ovf = 1'b1;
    end
    m_cnt++;
    if (m_cnt == n_terms_of(sel)) begin
      sb_q.push_back('{acc: 16'(m_acc), ovf: m_ovf});
      n_pushed++;
      check_eq("valid_latency", 32'(obs_valid), 32'd1);
    end
  endtask

  task automatic finish_job(input int hold, input bit with_start);
    repeat (hold) begin
      check_eq("valid_hold",   32'(obs_valid), 32'd1);
      check_eq("p_ready_done", 32'(obs_ready), 32'd0);
      tick();
    end
    s_acc_ready = 1'b1;
    s_start = with_start;
    tick();
    s_acc_ready = 1'b0;
    s_start = 1'b0;
    check_eq("valid_drop",   32'(obs_valid), 32'd0);
    check_eq("busy_idle",    32'(obs_busy),  32'd0);
    check_eq("p_ready_idle", 32'(obs_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    s_start = 1'b0;
    s_p_valid = 1'b0;
    s_acc_ready = 1'b0;
    P = '0;
    sel = 0;
    repeat (2) tick();
    do_reset();

    // products offered while idle must be refused and not summed
    s_p_valid = 1'b1;
    P = 8'd50;
    tick();
    check_eq("idle_p_ready", 32'(obs_ready), 32'd0);
    tick();
    s_p_valid = 1'b0;
    check_eq("idle_no_accum", 32'(obs_acc),  32'd0);
    check_eq("idle_busy",     32'(obs_busy), 32'd0);

    start_job();
    send(2); send(4); send(64); send(81);
    finish_job(0, 1'b0);

    start_job();
    send(100); tick(); send(100); tick(); send(100); tick(); send(100);
    finish_job(3, 1'b0);

    start_job();
    send(10); send(20);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check_eq("start_ignored_busy", 32'(obs_busy), 32'd1);
    send(30); send(40);
    finish_job(1, 1'b1);

    start_job();
    send(5); send(5);
    do_reset();
    start_job();
    send(1); send(1); send(1); send(1);
    finish_job(0, 1'b0);

    sel = 1;
    start_job();
    send(200); send(100);
    finish_job(0, 1'b0);
    check_eq("ovf_sticky_idle", 32'(obs_ovf), 32'd1);
    start_job();
    check_eq("ovf_cleared", 32'(obs_ovf), 32'd0);
    send(3); send(4);
    finish_job(0, 1'b0);
    start_job();
    send(255); send(255);
    finish_job(2, 1'b0);

    sel = 2;
    start_job();
    send(225);
    finish_job(0, 1'b0);
    start_job();
    send(0);
    finish_job(1, 1'b0);

    repeat (2) tick();
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    check_eq("results",  32'(n_popped),    32'(n_pushed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
